encoder8x3_pending: RTL and testbench

- Sequential 8-to-3 priority encoder; the inverse of the team's 3-to-8 decoder path.
- Captures rising edges on 8 request lines into a pending register.
- Encodes the highest-priority pending request into a 3-bit code and presents it on a valid/ready output.
- Clears each request as it is issued.
- Sits in front of a decoder/dispatcher so that several asynchronous-in-time request sources share one 3-bit code bus.

---
 rtl/encoder8x3_pending_if.sv | 17 +
 rtl/encoder8x3_pending.sv | 112 +++++++++++
 tb/tb_encoder8x3_pending.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/encoder8x3_pending_if.sv
// ---------------------------------------------------------------------------
// encoder8x3_pending_if : valid/ready code bus between the encoder and the
//                         downstream decoder/dispatcher.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface encoder8x3_pending_if;
  logic [2:0] Y;
  logic       V;
  logic       RDY;

  modport master (output Y, output V, input RDY);
  modport slave  (input Y, input V, output RDY);
endinterface

`default_nettype wire

// File: rtl/encoder8x3_pending.sv
// ---------------------------------------------------------------------------
// encoder8x3_pending : captures request rises into a pending register and
//                      issues one encoded index per transfer on a valid/ready bus.
// Optional macro ENC8X3_ROUND_ROBIN_EN selects rotating priority.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module encoder8x3_pending #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           E,
  input  wire logic [N-1:0]   REQ,
  encoder8x3_pending_if.master out_if,
  output logic      [N-1:0]   PEND,
  output logic                OVF
);

  if (N != 8 || W != 3) begin : g_size_check
    $error("encoder8x3_pending supports only N=8, W=3");
  end

  logic [N-1:0] r_req_q;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_y;
  logic         r_v;
  logic         r_ovf;

  logic [W-1:0] w_start;
  logic [W-1:0] w_sel;
  logic         w_slot_free;
  logic         w_load;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;

`ifdef ENC8X3_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd7;
    end else if (w_load) begin
      r_ptr <= w_sel - 3'd1;
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = 3'd7;
`endif

  // Search downward from w_start with wrap; first pending bit found wins.
  always_comb begin : p_search
    logic [W-1:0] cand;
    logic         found;
    w_sel = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = w_start - k[W-1:0];
      if (!found && r_pend[cand]) begin
        w_sel = cand;
        found = 1'b1;
      end
    end
  end

  assign w_slot_free = ~r_v | out_if.RDY;
  assign w_load      = w_slot_free & (|r_pend);
  assign w_set       = E ? (REQ & ~r_req_q) : '0;

  always_comb begin
    w_clr = '0;
    if (w_load) begin
      w_clr[w_sel] = 1'b1;
    end
  end

  // A rise on an issued bit re-sets it (set wins) and is not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_y     <= '0;
      r_v     <= 1'b0;
    end else begin
      r_req_q <= REQ;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_ovf   <= |(w_set & r_pend & ~w_clr);
      if (w_slot_free) begin
        if (w_load) begin
          r_y <= w_sel;
          r_v <= 1'b1;
        end else begin
          r_v <= 1'b0;
        end
      end
    end
  end

  assign out_if.Y = r_y;
  assign out_if.V = r_v;
  assign PEND     = r_pend;
  assign OVF      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_encoder8x3_pending.sv
// ---------------------------------------------------------------------------
// tb_encoder8x3_pending : directed self-checking bench for encoder8x3_pending.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_encoder8x3_pending;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [7:0] REQ;
  logic [7:0] PEND;
  logic       OVF;
  logic [12:0] obs;
  logic [12:0] exp_v;
  int checks;
  int failures;

  encoder8x3_pending_if u_if ();

  encoder8x3_pending u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .E      (E),
    .REQ    (REQ),
    .out_if (u_if),
    .PEND   (PEND),
    .OVF    (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {u_if.Y, u_if.V, PEND, OVF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; E = 1'b1; REQ = 8'h00; u_if.RDY = 1'b1;
    tick(); tick();
    exp_v = {3'd0, 1'b0, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
    rst_n = 1'b1; REQ = 8'h20;
    tick();
    exp_v = {3'd0, 1'b0, 8'h20, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rise5_e1 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd5, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rise5_e2 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd5, 1'b0, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rise5_e3 got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick();
  endtask

  task automatic test_two_bits();
    REQ = 8'h81;
    tick();
    exp_v = {3'd5, 1'b0, 8'h81, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL two_e1 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd7, 1'b1, 8'h01, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL two_e2 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd0, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL two_e3 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd0, 1'b0, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL two_e4 got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick();
  endtask

  task automatic test_hold();
    u_if.RDY = 1'b0; REQ = 8'h08;
    tick();
    exp_v = {3'd0, 1'b0, 8'h08, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL hold_cap got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd3, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL hold_load got=%h exp=%h", obs, exp_v); end
    REQ = 8'h48;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {3'd3, 1'b1, 8'h40, 1'b0}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL hold_stable%0d got=%h exp=%h", i, obs, exp_v); end
    end
    u_if.RDY = 1'b1;
    tick();
    exp_v = {3'd6, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL hold_next got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd6, 1'b0, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL hold_idle got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick();
  endtask

  task automatic test_overflow();
    u_if.RDY = 1'b0; REQ = 8'h02;
    tick(); tick();
    exp_v = {3'd1, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_hold got=%h exp=%h", obs, exp_v); end
    REQ = 8'h06; tick();
    exp_v = {3'd1, 1'b1, 8'h04, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_rise1 got=%h exp=%h", obs, exp_v); end
    REQ = 8'h02; tick();
    exp_v = {3'd1, 1'b1, 8'h04, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_fall got=%h exp=%h", obs, exp_v); end
    REQ = 8'h06; tick();
    exp_v = {3'd1, 1'b1, 8'h04, 1'b1}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_pulse got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd1, 1'b1, 8'h04, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_end got=%h exp=%h", obs, exp_v); end
    u_if.RDY = 1'b1; tick();
    exp_v = {3'd2, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_issue got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {3'd2, 1'b0, 8'h00, 1'b0}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL ovf_single%0d got=%h exp=%h", i, obs, exp_v); end
    end
    REQ = 8'h00; tick();
  endtask

  task automatic test_set_wins();
    u_if.RDY = 1'b0; REQ = 8'h08;
    tick(); tick();
    REQ = 8'h0C; tick();
    REQ = 8'h08; tick();
    exp_v = {3'd3, 1'b1, 8'h04, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sw_setup got=%h exp=%h", obs, exp_v); end
    u_if.RDY = 1'b1; REQ = 8'h0C; tick();
    exp_v = {3'd2, 1'b1, 8'h04, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sw_same got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd2, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sw_reissue got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick(); tick();
  endtask

  task automatic test_enable();
    E = 1'b0; REQ = 8'h10;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {3'd2, 1'b0, 8'h00, 1'b0}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL en_off%0d got=%h exp=%h", i, obs, exp_v); end
    end
    E = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {3'd2, 1'b0, 8'h00, 1'b0}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL en_on%0d got=%h exp=%h", i, obs, exp_v); end
    end
    REQ = 8'h00; tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mask;
    u_if.RDY = 1'b1; REQ = 8'hFF;
    tick();
    for (int k = 7; k >= 0; k--) begin
      tick();
      mask = 8'((9'd1 << k) - 9'd1);
      exp_v = {k[2:0], 1'b1, mask, 1'b0}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL ff_issue%0d got=%h exp=%h", k, obs, exp_v); end
    end
    REQ = 8'h00; tick();
    REQ = 8'h81; tick(); tick();
    exp_v = {3'd7, 1'b1, 8'h01, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL b2b_81_first got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {3'd0, 1'b1, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL b2b_81_second got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick();
    // Rise on bits 7 and 0 in the middle of a burst from 0x7E.
    REQ = 8'h7E; tick(); tick();
    REQ = 8'hFF; tick();
    exp_v = {3'd5, 1'b1, 8'h9F, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL burst_mid got=%h exp=%h", obs, exp_v); end
    tick();
`ifdef ENC8X3_ROUND_ROBIN_EN
    exp_v = {3'd4, 1'b1, 8'h8F, 1'b0};
`else
    exp_v = {3'd7, 1'b1, 8'h1F, 1'b0};
`endif
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL burst_prio got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00;
    repeat (10) tick();
    checks++;
    if ({u_if.V, PEND} !== 9'h000) begin failures++; $display("FAIL burst_drain got=%h exp=000", {u_if.V, PEND}); end
  endtask

  task automatic test_reset_mid();
    u_if.RDY = 1'b0; REQ = 8'h03;
    tick(); tick();
    exp_v = {3'd1, 1'b1, 8'h01, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_load got=%h exp=%h", obs, exp_v); end
    rst_n = 1'b0; #1;
    exp_v = {3'd0, 1'b0, 8'h00, 1'b0}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_async got=%h exp=%h", obs, exp_v); end
    REQ = 8'h00; tick();
    rst_n = 1'b1; u_if.RDY = 1'b1; tick(); tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_after got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_two_bits();
    test_hold();
    test_overflow();
    test_set_wins();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
